// File: rtl/lfsr_checker_if.sv
// Stream and status bundle for the PRBS-32 checker.
// The master side drives the received stream; the slave side (the checker)
// drives the registered status outputs.
interface lfsr_checker_if #(
   parameter int CNT_W = 16
) ();
   logic             in_valid;
   logic             in_bit;
   logic             clr_cnt;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_cnt;
   logic             sync_loss;

   modport master (
      output in_valid, in_bit, clr_cnt,
      input  locked, err, err_cnt, sync_loss
   );

   modport slave (
      input  in_valid, in_bit, clr_cnt,
      output locked, err, err_cnt, sync_loss
   );
endinterface

// File: rtl/lfsr_checker.sv
// PRBS-32 stream checker.
// Fills a 32-bit history from the received stream, verifies LOCK_LEN
// consecutive predictions, then runs locked on its own prediction so that
// isolated line errors do not corrupt the history. Errors are counted per
// WIN_LEN-bit window; ERR_THRESH errors within one window drop sync.
module lfsr_checker #(
   parameter int LOCK_LEN   = 32,
   parameter int WIN_LEN    = 64,
   parameter int ERR_THRESH = 8,
   parameter int CNT_W      = 16
) (
   input logic          clk,
   input logic          rst,
   lfsr_checker_if.slave bus
);

   localparam int MW = $clog2(LOCK_LEN + 1);
   localparam int WW = $clog2(WIN_LEN + 1);
   localparam int EW = $clog2(ERR_THRESH + 1);

   typedef enum logic [1:0] {
      FILL   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      h_q, h_d;
   logic [4:0]       fill_q, fill_d;
   logic [MW-1:0]    match_q, match_d;
   logic [WW-1:0]    wbit_q, wbit_d;
   logic [EW-1:0]    werr_q, werr_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             err_q, err_d;
   logic             loss_q, loss_d;
   logic             locked_q, locked_d;

   logic             pred;
   logic             miss;
   logic             cnt_inc;
   logic [EW:0]      werr_nxt;

   // Next stream bit predicted from the taps of the history.
   assign pred = h_q[31] ^ h_q[30] ^ h_q[29] ^ h_q[27] ^ h_q[25] ^ h_q[0];
   assign miss = bus.in_bit ^ pred;

   // Sync FSM: history update, fill/match/window counters and status pulses.
   always_comb begin
      state_d  = state_q;
      h_d      = h_q;
      fill_d   = fill_q;
      match_d  = match_q;
      wbit_d   = wbit_q;
      werr_d   = werr_q;
      err_d    = 1'b0;
      loss_d   = 1'b0;
      cnt_inc  = 1'b0;
      // Includes the current bit so a miss on the last bit of a window still
      // lands in the window it closes.
      werr_nxt = {1'b0, werr_q} + {{EW{1'b0}}, miss};
      if (bus.in_valid) begin
         unique case (state_q)
            FILL: begin
               h_d = {bus.in_bit, h_q[31:1]};
               if (fill_q == 5'd31) begin
                  state_d = VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + 5'd1;
               end
            end
            VERIFY: begin
               h_d = {bus.in_bit, h_q[31:1]};
               if (miss) begin
                  state_d = FILL;
                  fill_d  = '0;
                  match_d = '0;
               end else if (match_q == MW'(LOCK_LEN - 1)) begin
                  state_d = LOCKED;
                  match_d = '0;
                  wbit_d  = '0;
                  werr_d  = '0;
               end else begin
                  match_d = match_q + MW'(1);
               end
            end
            LOCKED: begin
               // Keep running on the prediction; the line bit only scores.
               h_d     = {pred, h_q[31:1]};
               err_d   = miss;
               cnt_inc = miss;
               if (werr_nxt >= (EW+1)'(ERR_THRESH)) begin
                  state_d = FILL;
                  loss_d  = 1'b1;
                  fill_d  = '0;
                  wbit_d  = '0;
                  werr_d  = '0;
               end else if (wbit_q == WW'(WIN_LEN - 1)) begin
                  wbit_d = '0;
                  werr_d = '0;
               end else begin
                  wbit_d = wbit_q + WW'(1);
                  werr_d = werr_nxt[EW-1:0];
               end
            end
            default: begin
               state_d = FILL;
               fill_d  = '0;
            end
         endcase
      end
      locked_d = (state_d == LOCKED);
   end

   // Saturating error total; a clear still keeps an error from the same cycle.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (bus.clr_cnt) begin
         err_cnt_d = CNT_W'(cnt_inc);
      end else if (cnt_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   // State and output registers, asynchronously cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= FILL;
         h_q       <= '0;
         fill_q    <= '0;
         match_q   <= '0;
         wbit_q    <= '0;
         werr_q    <= '0;
         err_cnt_q <= '0;
         err_q     <= 1'b0;
         loss_q    <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         wbit_q    <= wbit_d;
         werr_q    <= werr_d;
         err_cnt_q <= err_cnt_d;
         err_q     <= err_d;
         loss_q    <= loss_d;
         locked_q  <= locked_d;
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err       = err_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.sync_loss = loss_q;

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The block SHALL have parameter LOCK_LEN, default 32, meaning consecutive correct predictions required to declare lock.
REQ-002 The block SHALL have parameter WIN_LEN, default 64, meaning valid bits per sync-loss observation window.
REQ-003 The block SHALL have parameter ERR_THRESH, default 8, meaning errors within one window that force sync loss.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning width of the error counter.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  in_bit is a valid stream bit this cycle.
REQ-008 in_bit  input  1  received serial bit of the 32-bit PRBS stream.
REQ-009 clr_cnt  input  1  synchronous clear of err_cnt.
REQ-010 locked  output  1  high while in LOCKED state.
REQ-011 err  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-012 err_cnt  output  CNT_W  total errors since reset/clear, saturating.
REQ-013 sync_loss  output  1  one-cycle pulse when LOCKED drops to FILL.

Function
REQ-014 Sequence definition: with history h[31:0], predicted bit p = h[31]^h[30]^h[29]^h[27]^h[25]^h[0]; a valid bit shifts h <= {bit, h[31:1]}.
REQ-015 Cycles with in_valid=0 SHALL change no state, counter or output except clearing err/sync_loss pulses and applying clr_cnt.
REQ-016 States SHALL be FILL, VERIFY, LOCKED; all outputs registered.
REQ-017 FILL: each valid bit shifts in_bit into h; after 32 valid bits go to VERIFY with match counter 0.
REQ-018 VERIFY: each valid bit compared to p and in_bit shifted into h; match increments match counter; mismatch returns to FILL with fill count 0.
REQ-019 VERIFY to LOCKED when match counter reaches LOCK_LEN (on the LOCK_LEN-th consecutive match); locked high the following cycle.
REQ-020 LOCKED: h SHALL shift in p (not in_bit) so isolated errors do not corrupt the prediction.
REQ-021 LOCKED mismatch (in_bit != p): err=1 next cycle, err_cnt +1 saturating at 2^CNT_W-1, window error count +1.
REQ-022 Window: valid bits in LOCKED counted modulo WIN_LEN; window error count cleared at each window boundary, bit and error counts restart on entry to LOCKED.
REQ-023 When window error count reaches ERR_THRESH: next state FILL, sync_loss pulse, locked low, fill count 0; err for that bit still pulses.
REQ-024 A mismatch on the last bit of a window SHALL count in the closing window before its clear.
REQ-025 clr_cnt with a simultaneous error SHALL yield err_cnt = 1; clr_cnt wins over saturation.
REQ-026 err_cnt SHALL count only in LOCKED; FILL/VERIFY mismatches are not errors.

Reset
REQ-027 rst SHALL immediately force state FILL, h=0, all counters 0, locked=0, err=0, sync_loss=0, err_cnt=0, including mid-lock.
REQ-028 First valid bit after rst deassertion is fill bit 1.

Verification
REQ-029 Error-free generator stream (init 32'h974CA351) continuous valid -> locked rises after 32+32 valid bits (cycle 65), err_cnt stays 0 for 10000 bits.
REQ-030 After lock, invert 1 bit -> exactly one err pulse, err_cnt=1, locked stays 1, next bits no errors.
REQ-031 After lock, invert 8 bits within one 64-bit window -> sync_loss pulse on the 8th, locked=0, err_cnt=8, relock after 64 more valid bits.
REQ-032 Invert 7 bits in window N and 7 in window N+1 -> no sync_loss, err_cnt=14.
REQ-033 Random in_valid gaps (50%) on clean stream -> same lock after 64 valid bits, no errors; error during VERIFY -> back to FILL, lock delayed.
REQ-034 rst asserted mid-lock with err_cnt=5 -> locked=0, err_cnt=0 asynchronously; CNT_W=4 with 20 errors -> err_cnt=15.
